mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU MEM-stage, DMA control/OAM and data-memory signals for mem_port_arbiter.
// "slave" is the arbiter's view, "master" the surrounding system's view.
interface mem_port_arbiter_if #(parameter int LEN_W = 8);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              dma_start;
  logic [31:0]       dma_src;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_busy;
  logic              dma_done;
  logic              dma_wr_en;
  logic [LEN_W-1:0]  dma_wr_addr;
  logic [31:0]       dma_wr_data;
  logic [31:0]       mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_start, dma_src, dma_len, mem_rdata,
    output cpu_stall, dma_busy, dma_done, dma_wr_en, dma_wr_addr, dma_wr_data,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_start, dma_src, dma_len, mem_rdata,
    input  cpu_stall, dma_busy, dma_done, dma_wr_en, dma_wr_addr, dma_wr_data,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage and an OAM copy DMA.
// Optional macro CPU_PRIORITY_EN: a CPU request preempts the DMA during XFER.
module mem_port_arbiter #(
  parameter int LEN_W = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

`ifdef CPU_PRIORITY_EN
  localparam bit CpuPriority = 1'b1;
`else
  localparam bit CpuPriority = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [31:0]       src_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  pend_idx_q;
  logic              pend_q;
  logic              done_q;

  logic cpu_req, cpu_own, dma_issue, last_issue, start_go, start_empty;

  assign cpu_req     = bus.cpu_rd | bus.cpu_wr;
  // Outside XFER the CPU always owns the port; inside XFER only with priority enabled.
  assign cpu_own     = (state_q != XFER) || (CpuPriority && cpu_req);
  assign dma_issue   = !cpu_own;
  assign last_issue  = dma_issue && (count_q == len_q - LEN_W'(1));
  assign start_go    = (state_q == IDLE) && bus.dma_start && (bus.dma_len != '0);
  assign start_empty = (state_q == IDLE) && bus.dma_start && (bus.dma_len == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_go) state_d = XFER;
      XFER:    if (last_issue) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_re    = bus.cpu_rd;
    // A write is dropped if the CPU ever raises both, keeping re/we mutually exclusive.
    bus.mem_we    = bus.cpu_wr & ~bus.cpu_rd;
    bus.mem_wdata = bus.cpu_wdata;
    bus.cpu_stall = 1'b0;
    if (!cpu_own) begin
      bus.mem_addr  = src_q + 32'(count_q);
      bus.mem_re    = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      bus.cpu_stall = cpu_req;
    end
  end

  assign bus.dma_busy    = (state_q == XFER) || (state_q == DRAIN);
  assign bus.dma_done    = done_q || (state_q == DRAIN);
  assign bus.dma_wr_en   = pend_q;
  assign bus.dma_wr_addr = pend_idx_q;
  assign bus.dma_wr_data = bus.mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      pend_idx_q <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= start_empty;
      pend_q  <= dma_issue;
      if (dma_issue) begin
        pend_idx_q <= count_q;
        count_q    <= count_q + LEN_W'(1);
      end
      if (start_go) begin
        src_q   <= bus.dma_src;
        len_q   <= bus.dma_len;
        count_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory returns addr ^ 0x5A000000 one cycle after mem_re.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LEN_W(8)) bus();

  mem_port_arbiter #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= bus.mem_addr ^ 32'h5A00_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_start = 1'b0;
    bus.dma_src   = '0;
    bus.dma_len   = '0;
  endtask

  task automatic start(input logic [31:0] src, input logic [7:0] len);
    bus.dma_start = 1'b1;
    bus.dma_src   = src;
    bus.dma_len   = len;
  endtask

  // One cycle: sample at negedge with inputs already driven, then advance to posedge+1.
  task automatic expect_cycle(input string tag,
                              input logic busy, input logic done, input logic re,
                              input logic we, input logic stall, input logic wen,
                              input logic [31:0] addr, input logic [7:0] idx,
                              input logic [31:0] data);
    @(negedge clk);
    check({tag, ":flags"},
          {26'd0, bus.dma_busy, bus.dma_done, bus.mem_re, bus.mem_we, bus.cpu_stall, bus.dma_wr_en},
          {26'd0, busy, done, re, we, stall, wen});
    if (re || we) check({tag, ":addr"}, bus.mem_addr, addr);
    if (wen) begin
      check({tag, ":idx"}, {24'd0, bus.dma_wr_addr}, {24'd0, idx});
      check({tag, ":data"}, bus.dma_wr_data, data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state; CPU still routed to memory while held in reset.
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h0000_0040;
    expect_cycle("rst", 0,0,1,0,0,0, 32'h0000_0040, 8'd0, 32'd0);
    rst = 1'b0;
    idle_inputs();

    // len=4 from 0x100; CPU write in the start cycle is still performed.
    start(32'h0000_0100, 8'd4);
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 32'h0000_0200;
    bus.cpu_wdata = 32'hCAFE_F00D;
    #1;
    check("start:wdata", bus.mem_wdata, 32'hCAFE_F00D);
    expect_cycle("start4", 0,0,0,1,0,0, 32'h0000_0200, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("x4_0", 1,0,1,0,0,0, 32'h0000_0100, 8'd0, 32'd0);
    expect_cycle("x4_1", 1,0,1,0,0,1, 32'h0000_0101, 8'd0, 32'h5A00_0100);
    start(32'h0000_0900, 8'd9);   // ignored while busy
    expect_cycle("x4_2", 1,0,1,0,0,1, 32'h0000_0102, 8'd1, 32'h5A00_0101);
    idle_inputs();
    expect_cycle("x4_3", 1,0,1,0,0,1, 32'h0000_0103, 8'd2, 32'h5A00_0102);
    expect_cycle("d4",   1,1,0,0,0,1, 32'd0,         8'd3, 32'h5A00_0103);
    expect_cycle("i4",   0,0,0,0,0,0, 32'd0,         8'd0, 32'd0);

    // len=0: single done pulse, no access, never busy.
    start(32'h0000_0100, 8'd0);
    expect_cycle("z_start", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("z_done",  0,1,0,0,0,0, 32'd0, 8'd0, 32'd0);
    expect_cycle("z_after", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);

`ifndef CPU_PRIORITY_EN
    // CPU read held through a len=3 transfer: stalled in XFER, served in DRAIN.
    start(32'h0000_0300, 8'd3);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h0000_0044;
    expect_cycle("s_start", 0,0,1,0,0,0, 32'h0000_0044, 8'd0, 32'd0);
    bus.dma_start = 1'b0;
    expect_cycle("s_x0", 1,0,1,0,1,0, 32'h0000_0300, 8'd0, 32'd0);
    expect_cycle("s_x1", 1,0,1,0,1,1, 32'h0000_0301, 8'd0, 32'h5A00_0300);
    expect_cycle("s_x2", 1,0,1,0,1,1, 32'h0000_0302, 8'd1, 32'h5A00_0301);
    expect_cycle("s_d",  1,1,1,0,0,1, 32'h0000_0044, 8'd2, 32'h5A00_0302);
    idle_inputs();
    expect_cycle("s_i",  0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
`else
    // CPU write preempts the 2nd XFER cycle; DMA resumes and spans 4 cycles.
    start(32'h0000_0300, 8'd3);
    expect_cycle("p_start", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("p_x0", 1,0,1,0,0,0, 32'h0000_0300, 8'd0, 32'd0);
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 32'h0000_0080;
    bus.cpu_wdata = 32'h0000_DEAD;
    expect_cycle("p_cpu", 1,0,0,1,0,1, 32'h0000_0080, 8'd0, 32'h5A00_0300);
    idle_inputs();
    expect_cycle("p_x1", 1,0,1,0,0,0, 32'h0000_0301, 8'd0, 32'd0);
    expect_cycle("p_x2", 1,0,1,0,0,1, 32'h0000_0302, 8'd1, 32'h5A00_0301);
    expect_cycle("p_d",  1,1,0,0,0,1, 32'd0, 8'd2, 32'h5A00_0302);
    expect_cycle("p_i",  0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
`endif

    // Source address wraps modulo 2^32.
    start(32'hFFFF_FFFE, 8'd3);
    expect_cycle("w_start", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("w_x0", 1,0,1,0,0,0, 32'hFFFF_FFFE, 8'd0, 32'd0);
    expect_cycle("w_x1", 1,0,1,0,0,1, 32'hFFFF_FFFF, 8'd0, 32'hA5FF_FFFE);
    expect_cycle("w_x2", 1,0,1,0,0,1, 32'h0000_0000, 8'd1, 32'hA5FF_FFFF);
    expect_cycle("w_d",  1,1,0,0,0,1, 32'd0, 8'd2, 32'h5A00_0000);
    expect_cycle("w_i",  0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);

    // Reset on the 2nd XFER cycle aborts silently; a len=1 run then completes.
    start(32'h0000_0500, 8'd4);
    expect_cycle("r_start", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("r_x0", 1,0,1,0,0,0, 32'h0000_0500, 8'd0, 32'd0);
    rst = 1'b1;
    expect_cycle("r_x1", 1,0,1,0,0,1, 32'h0000_0501, 8'd0, 32'h5A00_0500);
    rst = 1'b0;
    expect_cycle("r_post", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    expect_cycle("r_post2", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    start(32'h0000_0600, 8'd1);
    expect_cycle("n_start", 0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);
    idle_inputs();
    expect_cycle("n_x0", 1,0,1,0,0,0, 32'h0000_0600, 8'd0, 32'd0);
    expect_cycle("n_d",  1,1,0,0,0,1, 32'd0, 8'd0, 32'h5A00_0600);
    expect_cycle("n_i",  0,0,0,0,0,0, 32'd0, 8'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
